ram_sync_ws: RTL and testbench

//  Clocked, parametrised byte-addressable RAM for the ARM datapath; successor of the combinational MOV/MOC RAM.

---
 rtl/ram_pkg.sv | 34 +++
 rtl/ram_rd_fmt.sv | 27 ++
 rtl/ram_sync_ws.sv | 167 ++++++++++++++++
 tb/tb_ram_sync_ws.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the clocked MOV/MOC byte RAM.
//   MS_*    : access size codes carried in MS_2_0[1:0]
//   state_t : handshake FSM states
//   req_t   : request fields captured when MOV is accepted
package ram_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;
  localparam logic [1:0] MS_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              rd;
    logic              sext;
    logic [1:0]        size;
    logic [DATA_W-1:0] data;
  } req_t;

  // Half needs A[0]=0, word needs A[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == MS_HALF) && lsb[0]) || ((size == MS_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/ram_rd_fmt.sv
// Read formatter: picks the addressed bytes out of a big-endian 4-byte
// window and zero- or sign-extends them to 32 bits.
//   raw    : {mem[A], mem[A+1], mem[A+2], mem[A+3]}
//   size   : access size code
//   sext   : sign-extend byte/half reads
//   word_c : right-justified, extended read data
module ram_rd_fmt
  import ram_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] word_c
);

  // The lowest address holds the MSB, so narrow reads come from the top of raw.
  always_comb begin
    word_c = '0;
    case (size)
      MS_BYTE: word_c = {{24{sext & raw[31]}}, raw[31:24]};
      MS_HALF: word_c = {{16{sext & raw[31]}}, raw[31:16]};
      MS_WORD: word_c = raw;
      default: word_c = '0;
    endcase
  end

endmodule

// File: rtl/ram_sync_ws.sv
// Clocked byte-addressable big-endian RAM with programmable wait states and
// a 4-phase MOV/MOC handshake; reports reserved-size and (optionally)
// misaligned accesses through Fault.
//   Clk, Reset_n : clock, async active-low reset (memory is not cleared)
//   MOV          : request valid, held until MOC is seen
//   ReadWrite    : 1 = read, 0 = write
//   MS_2_0       : [1:0] size, [2] sign-extend reads
//   Address      : byte address, low ADDR_W bits used
//   DataIn       : right-justified write data
//   MOC          : operation complete, held until MOV drops
//   Fault        : access rejected, valid with MOC
//   DataOut      : read data, held until the next successful read
module ram_sync_ws
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ALIGN_FAULT = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MOV,
  input  logic              ReadWrite,
  input  logic [2:0]        MS_2_0,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic              MOC,
  output logic              Fault,
  output logic [DATA_W-1:0] DataOut
);

  localparam int unsigned    DEPTH    = 1 << ADDR_W;
  localparam bit             ALIGN_EN = (ALIGN_FAULT != 0);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  req_t                req, req_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic                moc_n, fault_n;
  logic [DATA_W-1:0]   dout_n;

  logic [7:0]          mem [0:DEPTH-1];

  logic [ADDR_W-1:0]   idx0_c, idx1_c, idx2_c, idx3_c;
  logic                fault_c, wr_en_c;
  logic [DATA_W-1:0]   raw_c, rd_word_c;

  // Address bits above ADDR_W alias onto the array.
  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_W];
  end

  // Force-align by clearing the low bits; with ALIGN_EN a misaligned
  // request faults before this index is ever used for a write.
  always_comb begin
    idx0_c = addr;
    case (req.size)
      MS_HALF: idx0_c[0]   = 1'b0;
      MS_WORD: idx0_c[1:0] = 2'b00;
      default: ;
    endcase
  end

  // Byte indices wrap modulo DEPTH through natural ADDR_W-bit overflow.
  assign idx1_c = idx0_c + ADDR_W'(1);
  assign idx2_c = idx0_c + ADDR_W'(2);
  assign idx3_c = idx0_c + ADDR_W'(3);

  assign fault_c = (req.size == MS_RSVD) ||
                   (ALIGN_EN && is_misaligned(req.size, addr[1:0]));
  assign wr_en_c = (state == ST_ACCESS) && !req.rd && !fault_c;
  assign raw_c   = {mem[idx0_c], mem[idx1_c], mem[idx2_c], mem[idx3_c]};

  ram_rd_fmt u_rd_fmt (
    .raw    (raw_c),
    .size   (req.size),
    .sext   (req.sext),
    .word_c (rd_word_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    addr_n  = addr;
    moc_n   = MOC;
    fault_n = Fault;
    dout_n  = DataOut;
    case (state)
      ST_IDLE: begin
        if (MOV) begin
          req_n.rd   = ReadWrite;
          req_n.sext = MS_2_0[2];
          req_n.size = MS_2_0[1:0];
          req_n.data = DataIn;
          addr_n     = Address[ADDR_W-1:0];
          cnt_n      = WS_LOAD;
          state_n    = (WS_LOAD != '0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        // One WAIT cycle per wait state: leave on the cycle the counter reads 1.
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        moc_n   = 1'b1;
        fault_n = fault_c;
        if (req.rd && !fault_c) dout_n = rd_word_c;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        if (!MOV) begin
          moc_n   = 1'b0;
          fault_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req     <= '0;
      addr    <= '0;
      MOC     <= 1'b0;
      Fault   <= 1'b0;
      DataOut <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      req     <= req_n;
      addr    <= addr_n;
      MOC     <= moc_n;
      Fault   <= fault_n;
      DataOut <= dout_n;
    end
  end

  // Byte array; only the addressed bytes are written, contents survive reset.
  always_ff @(posedge Clk) begin
    if (wr_en_c) begin
      case (req.size)
        MS_BYTE: mem[idx0_c] <= req.data[7:0];
        MS_HALF: begin
          mem[idx0_c] <= req.data[15:8];
          mem[idx1_c] <= req.data[7:0];
        end
        MS_WORD: begin
          mem[idx0_c] <= req.data[31:24];
          mem[idx1_c] <= req.data[23:16];
          mem[idx2_c] <= req.data[15:8];
          mem[idx3_c] <= req.data[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_ws.sv
// Directed bench for ram_sync_ws. Three instances share one stimulus stream:
//   u0: WAIT_STATES=2, ALIGN_FAULT=0
//   u1: WAIT_STATES=2, ALIGN_FAULT=1
//   u2: WAIT_STATES=0, ALIGN_FAULT=0
module tb_ram_sync_ws;

  logic        Clk       = 1'b0;
  logic        Reset_n   = 1'b1;
  logic        MOV       = 1'b0;
  logic        ReadWrite = 1'b1;
  logic [2:0]  MS_2_0    = 3'b000;
  logic [31:0] Address   = 32'h0;
  logic [31:0] DataIn    = 32'h0;

  logic [2:0]  moc;
  logic [2:0]  fault;
  logic [31:0] dout [3];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int lat [3];

  ram_sync_ws #(.ADDR_W(8), .WAIT_STATES(2), .ALIGN_FAULT(0)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
    .Address(Address), .DataIn(DataIn), .MOC(moc[0]), .Fault(fault[0]), .DataOut(dout[0]));

  ram_sync_ws #(.ADDR_W(8), .WAIT_STATES(2), .ALIGN_FAULT(1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
    .Address(Address), .DataIn(DataIn), .MOC(moc[1]), .Fault(fault[1]), .DataOut(dout[1]));

  ram_sync_ws #(.ADDR_W(8), .WAIT_STATES(0), .ALIGN_FAULT(0)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
    .Address(Address), .DataIn(DataIn), .MOC(moc[2]), .Fault(fault[2]), .DataOut(dout[2]));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All instances idle: MOC and Fault low, DataOut as given.
  task automatic chk_idle(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2);
    logic [31:0] e [3];
    e[0] = d0; e[1] = d1; e[2] = d2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_moc_u%0d", tag, i), 32'(moc[i]), 32'h0);
      check($sformatf("%s_fault_u%0d", tag, i), 32'(fault[i]), 32'h0);
      check($sformatf("%s_dout_u%0d", tag, i), dout[i], e[i]);
    end
  endtask

  // All instances complete: MOC high, Fault per mask bit, DataOut as given.
  task automatic chk_done(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [2:0] f);
    logic [31:0] e [3];
    e[0] = d0; e[1] = d1; e[2] = d2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_moc_u%0d", tag, i), 32'(moc[i]), 32'h1);
      check($sformatf("%s_fault_u%0d", tag, i), 32'(fault[i]), 32'(f[i]));
      check($sformatf("%s_dout_u%0d", tag, i), dout[i], e[i]);
    end
  endtask

  // Raise MOV and wait (bounded) until every instance has raised MOC.
  task automatic xfer(input logic rw, input logic [2:0] ms, input logic [31:0] a,
                      input logic [31:0] d);
    logic [2:0] got;
    int start;
    got = 3'b000;
    @(negedge Clk);
    ReadWrite = rw; MS_2_0 = ms; Address = a; DataIn = d; MOV = 1'b1;
    start = cyc;
    for (int k = 0; k < 40 && got != 3'b111; k++) begin
      @(posedge Clk); #1;
      for (int i = 0; i < 3; i++)
        if (!got[i] && moc[i]) begin
          got[i] = 1'b1;
          lat[i] = cyc - start;
        end
    end
    if (got != 3'b111) check("handshake_timeout", 32'(got), 32'h7);
  endtask

  // Drop MOV; MOC and Fault must clear on the next edge.
  task automatic finish_op(input string tag);
    @(negedge Clk);
    MOV = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_mocfall_u%0d", tag, i), 32'(moc[i]), 32'h0);
      check($sformatf("%s_fltfall_u%0d", tag, i), 32'(fault[i]), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b [4];

    // Asynchronous reset with no clock edge involved.
    #2 Reset_n = 1'b0;
    #2 chk_idle("reset", 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Seed a known word, read it back.
    xfer(1'b0, 3'b010, 32'h08, 32'h11223344);
    chk_done("w08", 32'h0, 32'h0, 32'h0, 3'b000);
    finish_op("w08");
    xfer(1'b1, 3'b010, 32'h08, 32'h0);
    chk_done("r08", 32'h11223344, 32'h11223344, 32'h11223344, 3'b000);
    finish_op("r08");

    // Reset during the wait phase aborts the overwrite.
    @(negedge Clk);
    ReadWrite = 1'b0; MS_2_0 = 3'b010; Address = 32'h08; DataIn = 32'hCAFEF00D; MOV = 1'b1;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_idle("rst_mid", 32'h0, 32'h0, 32'h0);
    MOV = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    xfer(1'b1, 3'b010, 32'h08, 32'h0);
    chk_done("r08_post_rst", 32'h11223344, 32'h11223344, 32'h11223344, 3'b000);
    finish_op("r08_post_rst");

    // Word write, latency, DataOut untouched by writes.
    xfer(1'b0, 3'b010, 32'h04, 32'hDEADBEEF);
    chk_done("w04", 32'h11223344, 32'h11223344, 32'h11223344, 3'b000);
    check("lat_u0", 32'(lat[0]), 32'd4);
    check("lat_u1", 32'(lat[1]), 32'd4);
    check("lat_u2", 32'(lat[2]), 32'd2);
    finish_op("w04");

    // Big-endian byte order.
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 3'b000, 32'(4 + i), 32'h0);
      chk_done($sformatf("rb%0d", 4 + i), {24'h0, exp_b[i]}, {24'h0, exp_b[i]},
               {24'h0, exp_b[i]}, 3'b000);
      finish_op("rb");
    end

    // Byte write and sign/zero extension.
    xfer(1'b0, 3'b000, 32'h10, 32'h12345680);
    chk_done("wb10", 32'hEF, 32'hEF, 32'hEF, 3'b000);
    finish_op("wb10");
    xfer(1'b1, 3'b100, 32'h10, 32'h0);
    chk_done("rb10_s", 32'hFFFFFF80, 32'hFFFFFF80, 32'hFFFFFF80, 3'b000);
    finish_op("rb10_s");
    xfer(1'b1, 3'b000, 32'h10, 32'h0);
    chk_done("rb10_z", 32'h80, 32'h80, 32'h80, 3'b000);
    finish_op("rb10_z");

    // Misaligned half write: force-aligned on u0/u2, faulted on u1.
    xfer(1'b0, 3'b010, 32'h20, 32'h0);
    chk_done("w20", 32'h80, 32'h80, 32'h80, 3'b000);
    finish_op("w20");
    xfer(1'b0, 3'b001, 32'h21, 32'h00008001);
    chk_done("wh21", 32'h80, 32'h80, 32'h80, 3'b010);
    finish_op("wh21");
    xfer(1'b1, 3'b101, 32'h20, 32'h0);
    chk_done("rh20", 32'hFFFF8001, 32'h0, 32'hFFFF8001, 3'b000);
    finish_op("rh20");
    xfer(1'b1, 3'b101, 32'h21, 32'h0);
    chk_done("rh21", 32'hFFFF8001, 32'h0, 32'hFFFF8001, 3'b010);
    finish_op("rh21");

    // Misaligned word read; MS[2] ignored for words.
    xfer(1'b1, 3'b110, 32'h06, 32'h0);
    chk_done("rw06", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 3'b010);
    finish_op("rw06");

    // Reserved size faults everywhere and holds DataOut.
    xfer(1'b1, 3'b011, 32'h00, 32'h0);
    chk_done("rsvd", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 3'b111);
    finish_op("rsvd");

    // Upper address bits alias onto the top of the array.
    xfer(1'b0, 3'b010, 32'h000001FC, 32'hA1B2C3D4);
    chk_done("w1fc", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 3'b000);
    check("lat_top_u0", 32'(lat[0]), 32'd4);
    check("lat_top_u2", 32'(lat[2]), 32'd2);
    finish_op("w1fc");
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 3'b000, 32'(8'hFC + i), 32'h0);
      chk_done($sformatf("rbf%0d", i), {24'h0, exp_b[i]}, {24'h0, exp_b[i]},
               {24'h0, exp_b[i]}, 3'b000);
      finish_op("rbf");
    end
    xfer(1'b1, 3'b010, 32'h000001FC, 32'h0);
    chk_done("rw1fc", 32'hA1B2C3D4, 32'hA1B2C3D4, 32'hA1B2C3D4, 3'b000);
    finish_op("rw1fc");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
